// File: rtl/key_debounce.sv
// Debounces an active-low push-button into a level plus press/release/long-press pulses.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press detector; otherwise key_long is tied low.
module key_debounce #(
   parameter int DEB_CYCLES  = 200000,
   parameter int LONG_CYCLES = 10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int DW = $clog2(DEB_CYCLES);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   if (DEB_CYCLES < 2 || DEB_CYCLES > (1 << 20) ||
       LONG_CYCLES < 2 || LONG_CYCLES > (1 << 24)) begin : g_param_check
      $error("key_debounce: DEB_CYCLES or LONG_CYCLES out of range");
   end

   typedef enum logic [1:0] {IDLE, DEB_DN, PRESSED, DEB_UP} state_t;

   state_t          state_reg, state_next;
   logic [DW-1:0]   deb_cnt_reg, deb_cnt_next;
   logic            key_meta, key_sync;
   logic            press_next, release_next;

   // key_meta may be metastable; only key_sync is allowed to fan out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         deb_cnt_reg <= '0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         state_reg   <= state_next;
         deb_cnt_reg <= deb_cnt_next;
         key_press   <= press_next;
         key_release <= release_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      deb_cnt_next = deb_cnt_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!key_sync) begin
               state_next   = DEB_DN;
               deb_cnt_next = '0;
            end
         end
         DEB_DN: begin
            if (key_sync) begin
               state_next   = IDLE;
               deb_cnt_next = '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
               state_next   = PRESSED;
               deb_cnt_next = '0;
               press_next   = 1'b1;
            end else begin
               deb_cnt_next = deb_cnt_reg + DW'(1);
            end
         end
         PRESSED: begin
            if (key_sync) begin
               state_next   = DEB_UP;
               deb_cnt_next = '0;
            end
         end
         DEB_UP: begin
            if (!key_sync) begin
               state_next   = PRESSED;
               deb_cnt_next = '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
               state_next   = IDLE;
               deb_cnt_next = '0;
               release_next = 1'b1;
            end else begin
               deb_cnt_next = deb_cnt_reg + DW'(1);
            end
         end
         default: begin
            state_next   = IDLE;
            deb_cnt_next = '0;
         end
      endcase
   end

   // The key stays "down" while a release is still being debounced.
   assign key_state = (state_reg == PRESSED) || (state_reg == DEB_UP);

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
   localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);

   logic [23:0] long_cnt_reg;
   logic        long_done_reg;

   // Restarted only by a fresh accepted press, so release bounces do not re-arm it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         long_cnt_reg  <= '0;
         long_done_reg <= 1'b0;
         key_long      <= 1'b0;
      end else begin
         key_long <= 1'b0;
         if (press_next) begin
            long_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
         end else if (state_reg == PRESSED) begin
            if (long_cnt_reg != LONG_LAST) begin
               long_cnt_reg <= long_cnt_reg + 24'd1;
            end else if (!long_done_reg) begin
               key_long      <= 1'b1;
               long_done_reg <= 1'b1;
            end
         end
      end
   end
`else
   assign key_long = 1'b0;
`endif

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 200000, debounce window in clk cycles (20 ms at 10 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter LONG_CYCLES, default 10000000, long-press hold time in clk cycles (1 s at 10 MHz); legal range 2..2^24.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port key_n  input  1  raw board push-button, active-low, asynchronous to clk, may bounce.
REQ-006 SHALL have port key_state  output  1  debounced level, 1 = pressed.
REQ-007 SHALL have port key_press  output  1  one-cycle pulse on accepted press.
REQ-008 SHALL have port key_release  output  1  one-cycle pulse on accepted release.
REQ-009 SHALL have port key_long  output  1  one-cycle pulse when a press has been held LONG_CYCLES.

Function
REQ-010 SHALL pass key_n through a 2-flop synchronizer (key_meta, key_sync) before any other use; no logic on key_meta.
REQ-011 SHALL implement FSM states IDLE, DEB_DN, PRESSED, DEB_UP.
REQ-012 IDLE: key_sync==0 -> DEB_DN, deb counter := 0; else stay.
REQ-013 DEB_DN: key_sync==1 -> IDLE, counter cleared, no pulse (bounce rejected); key_sync==0 and counter==DEB_CYCLES-1 -> PRESSED with key_press=1 and key_state=1 registered on that edge; otherwise counter increments.
REQ-014 PRESSED: key_sync==1 -> DEB_UP, counter := 0; else stay.
REQ-015 DEB_UP: key_sync==0 -> PRESSED, counter cleared, no pulse; key_sync==1 and counter==DEB_CYCLES-1 -> IDLE with key_release=1 and key_state=0; otherwise counter increments.
REQ-016 key_state SHALL be 1 exactly in PRESSED and DEB_UP, 0 in IDLE and DEB_DN.
REQ-017 Latency: key_n held low from edge E onward SHALL give key_press high for exactly the one cycle following edge E+DEB_CYCLES+2 (2 sync edges + 1 IDLE edge + DEB_CYCLES counting edges); release symmetric for key_release.
REQ-018 Any single-level glitch shorter than DEB_CYCLES cycles after synchronization SHALL produce no pulse and no key_state change.
REQ-019 key_press, key_release, key_long SHALL never be high in the same cycle and never high for more than one consecutive cycle.
REQ-020 Deb counter width SHALL be ceil(log2(DEB_CYCLES)); it never wraps (cleared on every state exit).

Reset
REQ-021 With rst_n==0 at a rising edge: state := IDLE, all counters := 0, key_meta := 1, key_sync := 1, key_state/key_press/key_release/key_long := 0.
REQ-022 Reset asserted mid-debounce or mid-press SHALL abort without emitting any pulse; a key still held after reset release SHALL be re-debounced from IDLE and produce a fresh key_press.

Configuration
REQ-023 Macro KEY_DEBOUNCE_LONG_PRESS_EN SHALL gate the long-press logic.
REQ-024 Defined: in PRESSED a 24-bit long counter increments from 0 (cleared on PRESSED entry from DEB_DN only, held across DEB_UP bounces back to PRESSED); on reaching LONG_CYCLES-1 key_long pulses once and the counter saturates; at most one key_long per accepted press.
REQ-025 Not defined: no long counter is synthesized and key_long SHALL be tied to 0; port list unchanged.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, 100 ns clk, rst_n released after 5 cycles)
REQ-026 Clean press: key_n 1->0 at edge 10, held -> key_press high exactly in cycle after edge 16, key_state=1 from then.
REQ-027 Bounce: key_n low 3 cycles, high 1, low 2, then high -> no pulses, key_state stays 0.
REQ-028 Release: after REQ-026 press, key_n 0->1 at edge 40 -> key_release single pulse after edge 46, key_state=0.
REQ-029 Long press (macro defined): hold key_n low 40 cycles -> exactly one key_press, then one key_long 20 cycles after PRESSED entry; macro undefined -> key_long always 0.
REQ-030 Reset mid-press: key held, rst_n low 3 cycles during PRESSED -> all outputs 0 during reset, no key_release; after release, new key_press 7 cycles after rst_n rises.
